// File: rtl/booth_decode_acc_pkg.sv
// Shared constants and FSM state type for the radix-8 Booth decode/accumulate block.
package r8mbe_pkg;

    localparam int unsigned WIDTH        = 24;
    localparam int unsigned CONTROL_BITS = 5;
    localparam int unsigned NGROUPS      = 8;
    localparam int unsigned PROD_W       = 2 * WIDTH;
    localparam int unsigned CNT_W        = $clog2(NGROUPS);

    localparam int unsigned CTRL_NEG  = 4;
    localparam int unsigned CTRL_SEL4 = 3;
    localparam int unsigned CTRL_SEL3 = 2;
    localparam int unsigned CTRL_SEL2 = 1;
    localparam int unsigned CTRL_SEL1 = 0;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/booth_decode_acc_bd.sv
// Combinational Booth digit decoder: one control word plus X/3X to a signed
// 48-bit partial product (unshifted) and an illegal-encoding flag.
module bd
    import r8mbe_pkg::*;
(
    input  logic [CONTROL_BITS-1:0] control,
    input  logic [WIDTH-1:0]        x,
    input  logic [WIDTH+1:0]        x3,
    output logic [PROD_W-1:0]       pp,
    output logic                    illegal
);

    logic [PROD_W-1:0] mag;
    logic [3:0]        sel;

    always_comb begin
        sel     = control[CTRL_SEL4:CTRL_SEL1];
        mag     = '0;
        illegal = 1'b0;
        case (sel)
            4'b0000: mag = '0;
            4'b0001: mag = PROD_W'(x);
            4'b0010: mag = PROD_W'({x, 1'b0});
            4'b0100: mag = PROD_W'(x3);
            4'b1000: mag = PROD_W'({x, 2'b00});
            default: illegal = 1'b1;
        endcase
        // Negating a zero magnitude yields zero, so neg with no select is harmless.
        pp = control[CTRL_NEG] ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/booth_decode_acc.sv
// Radix-8 Booth digit decode and sequential accumulate: one operand set per
// transaction, one digit per cycle, product held until the consumer accepts it.
module booth_decode_acc
    import r8mbe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        x_in,
    input  logic [CONTROL_BITS-1:0] control1,
    input  logic [CONTROL_BITS-1:0] control2,
    input  logic [CONTROL_BITS-1:0] control3,
    input  logic [CONTROL_BITS-1:0] control4,
    input  logic [CONTROL_BITS-1:0] control5,
    input  logic [CONTROL_BITS-1:0] control6,
    input  logic [CONTROL_BITS-1:0] control7,
    input  logic [CONTROL_BITS-1:0] control8,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PROD_W-1:0]       product,
    output logic                    out_err
);

    state_t                                 state;
    logic [WIDTH-1:0]                       x_q;
    logic [WIDTH+1:0]                       x3_q;
    logic [NGROUPS-1:0][CONTROL_BITS-1:0]   ctrl_q;
    logic [CNT_W-1:0]                       cnt;
    logic [PROD_W-1:0]                      acc;
    logic                                   err_acc;
    logic [PROD_W-1:0]                      pp;
    logic [PROD_W-1:0]                      pp_shift;
    logic                                   illegal;
    logic [7:0]                             shamt;

    bd u_bd (
        .control (ctrl_q[cnt]),
        .x       (x_q),
        .x3      (x3_q),
        .pp      (pp),
        .illegal (illegal)
    );

    always_comb begin
        shamt    = 8'(cnt) * 8'd3;
        pp_shift = pp << shamt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            out_err   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            err_acc   <= 1'b0;
            x_q       <= '0;
            x3_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_q      <= x_in;
                        ctrl_q   <= {control8, control7, control6, control5,
                                     control4, control3, control2, control1};
                        in_ready <= 1'b0;
                        state    <= PRE;
                    end
                end
                PRE: begin
                    x3_q    <= {2'b00, x_q} + {1'b0, x_q, 1'b0};
                    acc     <= '0;
                    cnt     <= '0;
                    err_acc <= 1'b0;
                    state   <= ACC;
                end
                ACC: begin
                    acc     <= acc + pp_shift;
                    err_acc <= err_acc | illegal;
                    cnt     <= cnt + 1'b1;
                    // Final digit goes straight into the product register.
                    if (cnt == CNT_W'(NGROUPS - 1)) begin
                        product   <= acc + pp_shift;
                        out_err   <= err_acc | illegal;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_decode_acc.sv
// Self-checking bench for booth_decode_acc: directed cases, reset abort and
// randomized transactions against an arithmetic reference model.
module tb_booth_decode_acc;

    typedef logic [4:0] ctl_t [8];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] x_in = '0;
    ctl_t        ctl;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] product;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_decode_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .control1  (ctl[0]),
        .control2  (ctl[1]),
        .control3  (ctl[2]),
        .control4  (ctl[3]),
        .control5  (ctl[4]),
        .control6  (ctl[5]),
        .control7  (ctl[6]),
        .control8  (ctl[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Product = sum of digit_i * X * 8^i, digits decoded from the control rules.
    function automatic logic [47:0] model(input logic [23:0] x, input ctl_t c, output logic err);
        longint sum = 0;
        err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            longint mag = 0;
            longint d;
            if ($countones(c[i][3:0]) > 1) err = 1'b1;
            else if (c[i][0]) mag = 1;
            else if (c[i][1]) mag = 2;
            else if (c[i][2]) mag = 3;
            else if (c[i][3]) mag = 4;
            d = c[i][4] ? -mag : mag;
            sum += d * longint'(x) * (longint'(1) << (3 * i));
        end
        return 48'(sum);
    endfunction

    task automatic run_txn(input logic [23:0] x, input ctl_t c, input int hold,
                           input logic [47:0] want_p, input logic want_e);
        int lat;
        @(negedge clk);
        check("in_ready_idle", 48'(in_ready), 48'd1);
        in_valid = 1'b1;
        x_in     = x;
        ctl      = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = 24'($urandom);
        for (int i = 0; i < 8; i++) ctl[i] = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 48'(lat), 48'd9);
        check("product", product, want_p);
        check("out_err", 48'(out_err), 48'(want_e));
        check("in_ready_done", 48'(in_ready), 48'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            x_in     = 24'($urandom);
            @(negedge clk);
            check("hold_product", product, want_p);
            check("hold_valid", 48'(out_valid), 48'd1);
            check("hold_in_ready", 48'(in_ready), 48'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_valid", 48'(out_valid), 48'd0);
        check("idle_in_ready", 48'(in_ready), 48'd1);
        check("idle_product", product, want_p);
        check("idle_err", 48'(out_err), 48'(want_e));
    endtask

    task automatic run_model(input logic [23:0] x, input ctl_t c, input int hold);
        logic        e;
        logic [47:0] p;
        p = model(x, c, e);
        run_txn(x, c, hold, p, e);
    endtask

    ctl_t c;
    logic [4:0] legal_codes [9] = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
                                    5'b10001, 5'b10010, 5'b10100, 5'b11000};

    initial begin
        for (int i = 0; i < 8; i++) ctl[i] = '0;
        #12;
        check("rst_valid", 48'(out_valid), 48'd0);
        check("rst_product", product, 48'd0);
        check("rst_err", 48'(out_err), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 48'(in_ready), 48'd1);

        c = '{default: 5'b0}; c[0] = 5'b00001;
        run_txn(24'd5, c, 0, 48'h000000000005, 1'b0);
        c = '{default: 5'b0}; c[0] = 5'b10001;
        run_txn(24'hFFFFFF, c, 1, 48'hFFFFFF000001, 1'b0);
        c = '{default: 5'b0}; c[1] = 5'b00100;
        run_txn(24'd7, c, 0, 48'h0000000000A8, 1'b0);
        c = '{default: 5'b0}; c[7] = 5'b11000;
        run_txn(24'hFFFFFF, c, 0, 48'h800000800000, 1'b0);
        c = '{default: 5'b0}; c[0] = 5'b00001; c[2] = 5'b00011;
        run_txn(24'd1, c, 0, 48'h000000000001, 1'b1);
        c = '{default: 5'b0}; c[0] = 5'b10001;
        run_txn(24'hFFFFFF, c, 5, 48'hFFFFFF000001, 1'b0);

        // Reset during the 4th ACC cycle.
        c = '{default: 5'b01000};
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 24'h123456;
        ctl      = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 48'(out_valid), 48'd0);
        check("abort_product", product, 48'd0);
        check("abort_err", 48'(out_err), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 48'(in_ready), 48'd1);
        c = '{default: 5'b0}; c[0] = 5'b00001;
        run_txn(24'd5, c, 0, 48'h000000000005, 1'b0);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) c[i] = 5'($urandom);
                else c[i] = legal_codes[$urandom_range(0, 8)];
            end
            run_model(24'($urandom), c, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_decode_acc.md
BOOTH_DECODE_ACC -- requirements
Module: booth_decode_acc

Interface
REQ-001 Parameter WIDTH, 24, multiplicand width (localparam).
REQ-002 Parameter CONTROL_BITS, 5, Booth control word width (localparam).
REQ-003 Parameter NGROUPS, 8, number of radix-8 digits (localparam).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 in_valid  in  1  operand set valid.
REQ-008 in_ready  out  1  block can accept operands.
REQ-009 x_in  in  24  multiplicand X, unsigned.
REQ-010 control1..control8  in  5 each  Booth digit controls, LSB digit first; bit4 neg, bit3 sel4, bit2 sel3, bit1 sel2, bit0 sel1.
REQ-011 out_valid  out  1  product valid.
REQ-012 out_ready  in  1  consumer accepts product.
REQ-013 product  out  48  two's-complement product.
REQ-014 out_err  out  1  at least one control word was illegal.

Function
REQ-015 Digit value SHALL be magnitude (1/2/3/4 from the single set sel bit, 0 if none) negated when neg=1; neg with zero magnitude SHALL yield 0.
REQ-016 A control word with more than one sel bit set SHALL count as digit 0 and set the error flag for the transaction.
REQ-017 product SHALL equal sum over i=0..7 of digit_i * X * 8^i, modulo 2^48.
REQ-018 FSM states IDLE, PRE, ACC, DONE; in_ready=1 only in IDLE.
REQ-019 IDLE->PRE on in_valid&&in_ready; x_in and all controls registered at that edge; later input changes SHALL have no effect.
REQ-020 PRE->ACC after one cycle; 3X registered, accumulator cleared, digit counter set to 0.
REQ-021 ACC: each cycle add sign-extended 48-bit partial product of digit[cnt], shifted left 3*cnt, increment cnt; after cnt==7 go to DONE (8 ACC cycles).
REQ-022 out_valid SHALL rise 9 clock cycles after the accepting edge and be asserted only in DONE.
REQ-023 DONE: product and out_err SHALL hold stable while out_ready=0; DONE->IDLE on out_ready=1.
REQ-024 in_valid outside IDLE SHALL be ignored; no overlap of transactions (minimum 10 cycles per operation).
REQ-025 product and out_err SHALL keep their last values in IDLE until the next DONE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, product=0, out_err=0, counter=0, accumulator=0.
REQ-027 Reset in any state, including mid-ACC, SHALL abort the transaction with no partial result visible.

Structure
REQ-028 Package r8mbe_pkg SHALL hold WIDTH, CONTROL_BITS, NGROUPS, control bit index constants and the FSM state enum typedef.
REQ-029 Sub-module bd (combinational Booth digit decoder: control, X, 3X -> 48-bit signed partial product, illegal flag) SHALL be instantiated once and fed from the counter-selected control word.

Verification
REQ-030 X=5, control1=5'b00001, others 0 -> product=48'h000000000005, out_err=0, out_valid 9 cycles after accept.
REQ-031 X=24'hFFFFFF, control1=5'b10001, others 0 -> product=48'hFFFFFF000001.
REQ-032 X=7, control2=5'b00100, others 0 -> product=48'h0000000000A8; X=24'hFFFFFF, control8=5'b11000, others 0 -> product=48'h800000800000.
REQ-033 X=1, control1=5'b00001, control3=5'b00011 -> product=1, out_err=1.
REQ-034 out_ready held low 5 cycles in DONE with in_valid=1 -> product stable, in_ready=0, no new operand captured; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low in 4th ACC cycle -> out_valid=0, product=0 immediately; next transaction (X=5, control1=+1) returns 5.
